// File: rtl/diff_strobe_rx.sv
// diff_strobe_rx: receive side of a differential strobe pad pair; decodes the line
//   symbol, checks the preamble, counts strobe rising edges per burst, flags errors.
// Latency: pad -> decoded symbol SYNC_STAGES cycles; pad -> edge_o/flags SYNC_STAGES+1.
// Backpressure: none; the receiver always listens and error flags stay set until clr_err.
//
// Ports:
//   clk, rst          sole clock (posedge) and asynchronous active-high reset
//   pad_io_h/_l       true and complement legs of the strobe (shared tri nets)
//   en                receive enable; low forces IDLE without flagging anything
//   clr_err           clears the sticky error flags (a same-cycle set wins)
//   active            FSM is in PRE, ACTIVE or POST
//   edge_o            one-cycle pulse per counted strobe rising edge
//   edge_cnt          edges counted in the current burst
//   burst_done        one-cycle pulse with the edge that completes the burst
//   err_illegal       sticky: 11 symbol seen
//   err_preamble      sticky: rising edge before enough ZERO symbols
//   err_trunc         sticky: burst aborted by IDLE symbol or stall timeout
module diff_strobe_rx #(
    parameter int  SYNC_STAGES     = 2,
    parameter int  PREAMBLE_CYCLES = 2,
    parameter int  BURST_EDGES     = 4,
    parameter int  TIMEOUT         = 8,
    localparam int CNT_W           = $clog2(BURST_EDGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pad_io_h,
    input  logic             pad_io_l,
    input  logic             en,
    input  logic             clr_err,
    output logic             active,
    output logic             edge_o,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             burst_done,
    output logic             err_illegal,
    output logic             err_preamble,
    output logic             err_trunc
);

    localparam int PRE_W   = $clog2(PREAMBLE_CYCLES + 1);
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(PREAMBLE_CYCLES);
    localparam logic [PRE_W-1:0]   PRE_ONE   = PRE_W'(1);
    localparam logic [CNT_W-1:0]   BURST_MAX = CNT_W'(BURST_EDGES);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

    // Line symbol encoding is {h, l} straight off the pads.
    typedef enum logic [1:0] {
        SYM_IDLE = 2'b00,
        SYM_ZERO = 2'b01,
        SYM_ONE  = 2'b10,
        SYM_ILL  = 2'b11
    } sym_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_ACTIVE,
        ST_POST
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers: both legs shift in parallel, decode uses the last stage.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] h_sync_q;
    logic [SYNC_STAGES-1:0] l_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_sync_q <= '0;
            l_sync_q <= '0;
        end else begin
            h_sync_q <= {h_sync_q[SYNC_STAGES-2:0], pad_io_h};
            l_sync_q <= {l_sync_q[SYNC_STAGES-2:0], pad_io_l};
        end
    end

    sym_t sym;
    assign sym = sym_t'({h_sync_q[SYNC_STAGES-1], l_sync_q[SYNC_STAGES-1]});

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    sym_t                prev_sym_q;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                active_q, edge_q, done_q;
    logic                err_ill_q, err_pre_q, err_trunc_q;
    logic                edge_d, done_d;
    logic                set_ill, set_pre, set_trunc;
    logic                rise;

    // A rising edge needs ZERO immediately before ONE; ONE straight after IDLE is not one.
    assign rise = (prev_sym_q == SYM_ZERO) && (sym == SYM_ONE);

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        edge_cnt_d = edge_cnt_q;
        stall_d    = stall_q;
        edge_d     = 1'b0;
        done_d     = 1'b0;
        set_ill    = 1'b0;
        set_pre    = 1'b0;
        set_trunc  = 1'b0;

        if (!en) begin
            // Disable is not a protocol fault: drop to IDLE, counters keep their value.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sym == SYM_ILL) begin
                        set_ill = 1'b1;
                    end else if (sym == SYM_ZERO) begin
                        state_d    = ST_PRE;
                        pre_cnt_d  = PRE_ONE;
                        edge_cnt_d = '0;
                    end
                end

                ST_PRE: begin
                    case (sym)
                        SYM_ZERO: begin
                            if (pre_cnt_q < PRE_MAX) begin
                                pre_cnt_d = pre_cnt_q + PRE_ONE;
                            end
                        end
                        SYM_ONE: begin
                            if (pre_cnt_q >= PRE_MAX) begin
                                // The ONE closing the preamble is the first counted edge.
                                edge_d     = 1'b1;
                                edge_cnt_d = CNT_ONE;
                                stall_d    = STALL_ONE;
                                if (BURST_EDGES == 1) begin
                                    done_d  = 1'b1;
                                    state_d = ST_POST;
                                end else begin
                                    state_d = ST_ACTIVE;
                                end
                            end else begin
                                set_pre = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                        SYM_IDLE: begin
                            state_d = ST_IDLE;
                        end
                        default: begin
                            set_ill = 1'b1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end

                ST_ACTIVE: begin
                    // stall counts how many cycles the current symbol has been seen.
                    if (sym != prev_sym_q) begin
                        stall_d = STALL_ONE;
                    end else begin
                        stall_d = stall_q + STALL_ONE;
                    end

                    if (rise) begin
                        edge_d     = 1'b1;
                        edge_cnt_d = edge_cnt_q + CNT_ONE;
                        if (edge_cnt_d == BURST_MAX) begin
                            done_d  = 1'b1;
                            state_d = ST_POST;
                        end
                    end else if (sym == SYM_IDLE) begin
                        set_trunc = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (sym == SYM_ILL) begin
                        set_ill = 1'b1;
                        state_d = ST_IDLE;
                    end else if (stall_d >= STALL_MAX) begin
                        set_trunc = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end

                ST_POST: begin
                    if (sym == SYM_IDLE) begin
                        state_d = ST_IDLE;
                    end else if (sym == SYM_ILL) begin
                        set_ill = 1'b1;
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prev_sym_q  <= SYM_IDLE;
            pre_cnt_q   <= '0;
            edge_cnt_q  <= '0;
            stall_q     <= '0;
            active_q    <= 1'b0;
            edge_q      <= 1'b0;
            done_q      <= 1'b0;
            err_ill_q   <= 1'b0;
            err_pre_q   <= 1'b0;
            err_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_sym_q  <= sym;
            pre_cnt_q   <= pre_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            stall_q     <= stall_d;
            active_q    <= (state_d != ST_IDLE);
            edge_q      <= edge_d;
            done_q      <= done_d;
            // Sticky flags: a set in the same cycle as clr_err keeps the flag up.
            err_ill_q   <= set_ill   | (err_ill_q   & ~clr_err);
            err_pre_q   <= set_pre   | (err_pre_q   & ~clr_err);
            err_trunc_q <= set_trunc | (err_trunc_q & ~clr_err);
        end
    end

    assign active       = active_q;
    assign edge_o       = edge_q;
    assign edge_cnt     = edge_cnt_q;
    assign burst_done   = done_q;
    assign err_illegal  = err_ill_q;
    assign err_preamble = err_pre_q;
    assign err_trunc    = err_trunc_q;

endmodule

// File: tb/tb_diff_strobe_rx.sv
// tb_diff_strobe_rx: stimulus and checking for diff_strobe_rx.
// Inputs are driven on the falling edge, outputs sampled 1 ns after the rising edge.
// A reference model computes the expected outputs from the symbol history.
`timescale 1ns/1ps
module tb_diff_strobe_rx;

    localparam int SYNC_STAGES     = 2;
    localparam int PREAMBLE_CYCLES = 2;
    localparam int BURST_EDGES     = 4;
    localparam int TIMEOUT         = 8;
    localparam int CNT_W           = $clog2(BURST_EDGES + 1);
    localparam int OUT_W           = CNT_W + 6;

    // Pad pairs {h, l}
    localparam logic [1:0] P00 = 2'b00;
    localparam logic [1:0] PZ  = 2'b01;
    localparam logic [1:0] PO  = 2'b10;
    localparam logic [1:0] P11 = 2'b11;

    localparam int M_OFF   = 0;
    localparam int M_PRE   = 1;
    localparam int M_BURST = 2;
    localparam int M_TAIL  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             pad_io_h, pad_io_l, en, clr_err;
    logic             active, edge_o, burst_done;
    logic [CNT_W-1:0] edge_cnt;
    logic             err_illegal, err_preamble, err_trunc;

    int n_tests = 0;
    int n_fail  = 0;

    diff_strobe_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .PREAMBLE_CYCLES(PREAMBLE_CYCLES),
        .BURST_EDGES    (BURST_EDGES),
        .TIMEOUT        (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pad_io_h    (pad_io_h),
        .pad_io_l    (pad_io_l),
        .en          (en),
        .clr_err     (clr_err),
        .active      (active),
        .edge_o      (edge_o),
        .edge_cnt    (edge_cnt),
        .burst_done  (burst_done),
        .err_illegal (err_illegal),
        .err_preamble(err_preamble),
        .err_trunc   (err_trunc)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [1:0] m_pipe[$];   // pads still travelling through the synchronizers
    logic [1:0] m_syms[$];   // recent decoded symbols, newest last
    int m_mode, m_pre, m_cnt;
    bit m_edge, m_done, m_ill, m_perr, m_trunc;

    task automatic model_reset();
        m_pipe.delete();
        m_syms.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(P00);
        m_syms.push_back(P00);
        m_mode = M_OFF; m_pre = 0; m_cnt = 0;
        m_edge = 0; m_done = 0; m_ill = 0; m_perr = 0; m_trunc = 0;
    endtask

    task automatic model_step(input logic [1:0] pad, input bit e, input bit c);
        logic [1:0] s, prev;
        int run;
        bit si, sp, st;
        si = 0; sp = 0; st = 0;
        m_pipe.push_back(pad);
        s = m_pipe.pop_front();
        prev = m_syms[m_syms.size()-1];
        run = 1;
        for (int i = m_syms.size() - 1; i >= 0; i--) begin
            if (m_syms[i] != s) break;
            run++;
        end
        m_syms.push_back(s);
        if (m_syms.size() > TIMEOUT + 2) m_syms.delete(0);

        m_edge = 0;
        m_done = 0;
        if (!e) begin
            m_mode = M_OFF;
        end else if (m_mode == M_OFF) begin
            if (s == P11) si = 1;
            else if (s == PZ) begin m_mode = M_PRE; m_pre = 1; m_cnt = 0; end
        end else if (m_mode == M_PRE) begin
            if (s == PZ) m_pre = (m_pre + 1 > PREAMBLE_CYCLES) ? PREAMBLE_CYCLES : m_pre + 1;
            else if (s == PO) begin
                if (m_pre >= PREAMBLE_CYCLES) begin
                    m_edge = 1; m_cnt = 1;
                    if (m_cnt == BURST_EDGES) begin m_done = 1; m_mode = M_TAIL; end
                    else m_mode = M_BURST;
                end else begin
                    sp = 1; m_mode = M_OFF;
                end
            end else if (s == P00) m_mode = M_OFF;
            else begin si = 1; m_mode = M_OFF; end
        end else if (m_mode == M_BURST) begin
            if (prev == PZ && s == PO) begin
                m_edge = 1; m_cnt++;
                if (m_cnt == BURST_EDGES) begin m_done = 1; m_mode = M_TAIL; end
            end else if (s == P00) begin st = 1; m_mode = M_OFF; end
            else if (s == P11) begin si = 1; m_mode = M_OFF; end
            else if (run >= TIMEOUT) begin st = 1; m_mode = M_OFF; end
        end else begin
            if (s == P00) m_mode = M_OFF;
            else if (s == P11) begin si = 1; m_mode = M_OFF; end
        end
        m_ill   = si | (m_ill   & ~c);
        m_perr  = sp | (m_perr  & ~c);
        m_trunc = st | (m_trunc & ~c);
    endtask

    function automatic logic [OUT_W-1:0] model_vec();
        return {m_mode != M_OFF, m_edge, CNT_W'(m_cnt), m_done, m_ill, m_perr, m_trunc};
    endfunction

    function automatic logic [OUT_W-1:0] dut_vec();
        return {active, edge_o, edge_cnt, burst_done, err_illegal, err_preamble, err_trunc};
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got act=%0b edge=%0b cnt=%0d done=%0b err(ill,pre,trunc)=%03b, want act=%0b edge=%0b cnt=%0d done=%0b err=%03b",
                     name, $time, got[OUT_W-1], got[OUT_W-2], got[CNT_W+3:4], got[3], got[2:0],
                     exp[OUT_W-1], exp[OUT_W-2], exp[CNT_W+3:4], exp[3], exp[2:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [1:0] pad, input bit e, input bit c, input string name);
        {pad_io_h, pad_io_l} = pad;
        en      = e;
        clr_err = c;
        model_step(pad, e, c);
        @(posedge clk);
        #1;
        check(name, dut_vec(), model_vec());
        @(negedge clk);
    endtask

    // Three ZEROs, then n rising edges; ends on the last ONE.
    task automatic burst_start(input int n, input string name);
        repeat (3) step(PZ, 1, 0, name);
        for (int k = 0; k < n; k++) begin
            if (k > 0) step(PZ, 1, 0, name);
            step(PO, 1, 0, name);
        end
    endtask

    task automatic flush(input string name);
        repeat (3) step(P00, 1, 1, name);
    endtask

    // Reset asserted mid-cycle, away from any clock edge.
    task automatic async_reset(input string name);
        #2 rst = 1'b1;
        #1;
        check(name, dut_vec(), '0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]       pad;
        bit               en;
        bit               clr;
        logic [OUT_W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [1:0] pad, input bit e, input bit c, input bit act,
                           input bit edg, input int cnt, input bit done, input logic [2:0] errs);
        vec_t v;
        v.pad = pad; v.en = e; v.clr = c;
        v.exp = {act, edg, CNT_W'(cnt), done, errs};
        vecs.push_back(v);
    endtask

    initial begin
        logic [1:0] rp;
        int hold;
        int r;

        rst = 1'b1; pad_io_h = 1'b0; pad_io_l = 1'b0; en = 1'b0; clr_err = 1'b0;
        #3;
        check("reset", dut_vec(), '0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Full burst: outputs lag pads by SYNC_STAGES rows, edge/done pulses registered.
        add_vec(P00, 1, 0, 0, 0, 0, 0, 3'b000);
        add_vec(P00, 1, 0, 0, 0, 0, 0, 3'b000);
        add_vec(PZ,  1, 0, 0, 0, 0, 0, 3'b000);
        add_vec(PZ,  1, 0, 0, 0, 0, 0, 3'b000);
        add_vec(PZ,  1, 0, 1, 0, 0, 0, 3'b000);
        add_vec(PO,  1, 0, 1, 0, 0, 0, 3'b000);
        add_vec(PZ,  1, 0, 1, 0, 0, 0, 3'b000);
        add_vec(PO,  1, 0, 1, 1, 1, 0, 3'b000);
        add_vec(PZ,  1, 0, 1, 0, 1, 0, 3'b000);
        add_vec(PO,  1, 0, 1, 1, 2, 0, 3'b000);
        add_vec(PZ,  1, 0, 1, 0, 2, 0, 3'b000);
        add_vec(PO,  1, 0, 1, 1, 3, 0, 3'b000);
        add_vec(P00, 1, 0, 1, 0, 3, 0, 3'b000);
        add_vec(P00, 1, 0, 1, 1, 4, 1, 3'b000);
        add_vec(P00, 1, 0, 0, 0, 4, 0, 3'b000);
        add_vec(P00, 1, 0, 0, 0, 4, 0, 3'b000);
        // Short preamble: one ZERO then ONE.
        add_vec(PZ,  1, 0, 0, 0, 4, 0, 3'b000);
        add_vec(PO,  1, 0, 0, 0, 4, 0, 3'b000);
        add_vec(P00, 1, 0, 1, 0, 0, 0, 3'b000);
        add_vec(P00, 1, 0, 0, 0, 0, 0, 3'b010);
        add_vec(P00, 1, 0, 0, 0, 0, 0, 3'b010);
        add_vec(P00, 1, 1, 0, 0, 0, 0, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].pad, vecs[i].en, vecs[i].clr, "model_vec");
            check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
        end

        // Stall: two edges then ONE held past the timeout.
        flush("flush3");
        burst_start(2, "trunc");
        repeat (11) step(PO, 1, 0, "trunc_hold");
        repeat (3) step(P00, 1, 0, "trunc_idle");
        check_int("trunc_flag", int'(err_trunc), 1);
        check_int("trunc_cnt", int'(edge_cnt), 2);
        check_int("trunc_active", int'(active), 0);

        // Illegal symbol mid-burst, clr_err while it persists.
        flush("flush4");
        burst_start(1, "ill");
        step(PZ, 1, 0, "ill");
        repeat (3) step(P11, 1, 0, "ill_pad");
        step(P11, 1, 1, "ill_clr");
        check_int("ill_set_wins", int'(err_illegal), 1);
        check_int("ill_active", int'(active), 0);
        step(P11, 1, 0, "ill_pad");
        step(P00, 1, 0, "ill_release");
        step(P00, 1, 1, "ill_clr2");
        step(P00, 1, 1, "ill_clr3");
        check_int("ill_cleared", int'(err_illegal), 0);

        // Asynchronous reset between edges 2 and 3, then a fresh full burst.
        flush("flush5");
        burst_start(2, "rst_burst");
        step(PZ, 1, 0, "rst_burst");
        step(PZ, 1, 0, "rst_burst");
        check_int("rst_pre_cnt", int'(edge_cnt), 2);
        async_reset("rst_async");
        burst_start(4, "rst_fresh");
        repeat (3) step(P00, 1, 0, "rst_fresh_idle");
        check_int("rst_fresh_cnt", int'(edge_cnt), 4);
        check_int("rst_fresh_active", int'(active), 0);
        check_int("rst_fresh_errs", int'({err_illegal, err_preamble, err_trunc}), 0);

        // Enable dropped mid-burst, then re-enabled with a new preamble.
        flush("flush6");
        burst_start(2, "en_burst");
        step(PZ, 1, 0, "en_burst");
        step(PZ, 1, 0, "en_burst");
        step(P00, 0, 0, "en_drop");
        check_int("en_drop_active", int'(active), 0);
        check_int("en_drop_cnt", int'(edge_cnt), 2);
        check_int("en_drop_errs", int'({err_illegal, err_preamble, err_trunc}), 0);
        repeat (2) step(P00, 0, 0, "en_off");
        repeat (3) step(PZ, 1, 0, "en_again");
        check_int("en_again_active", int'(active), 1);
        check_int("en_again_cnt", int'(edge_cnt), 0);

        // Random traffic against the model.
        rp = PZ;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold > 0) begin
                hold--;
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 42)      rp = PZ;
                else if (r < 84) rp = PO;
                else if (r < 91) rp = P00;
                else if (r < 94) rp = P11;
                else             hold = int'($urandom_range(3, 11));
            end
            step(rp, ($urandom_range(0, 99) < 97), ($urandom_range(0, 99) < 4), "rand");
            if ($urandom_range(0, 999) < 2) async_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
